adc16dv160_capture_ctrl: RTL and testbench

ADC16DV160_CAPTURE_CTRL -- requirements
Module: adc16dv160_capture_ctrl

---
 rtl/adc16dv160_capture_ctrl.sv | 130 +++++++++++++
 tb/tb_adc16dv160_capture_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/adc16dv160_capture_ctrl.sv
// rtl/adc16dv160_capture_ctrl.sv - ADC16DV160 sample packer: two 16-bit samples per 32-bit stream word
module adc16dv160_capture_ctrl (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        cr_start,
  input  logic        cr_test,
  input  logic        cr_rt,
  input  logic [31:0] dsize,
  input  logic [15:0] adc_data,
  input  logic        adc_valid,
  output logic [31:0] M_AXIS_TDATA,
  output logic        M_AXIS_TVALID,
  input  logic        M_AXIS_TREADY,
  output logic        M_AXIS_TLAST,
  output logic        busy,
  output logic        done,
  output logic        ovf
);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  state_t      state_q;
  logic [31:0] len_q;
  logic [31:0] cnt_q;
  logic        half_q;
  logic [15:0] lo_q;
  logic [15:0] tcnt_q;
  logic [31:0] tdata_q;
  logic        tvalid_q;
  logic        tlast_q;
  logic        busy_q;
  logic        done_q;
  logic        ovf_q;

  logic [15:0] sample_d;
  logic [31:0] cnt_d;
  logic        last_d;
  logic        can_load_d;

  assign sample_d   = cr_test ? tcnt_q : adc_data;
  assign cnt_d      = cnt_q + 32'd1;
  assign last_d     = (cnt_d == len_q);
  // The output register can take a new word if empty or being emptied this cycle.
  assign can_load_d = !tvalid_q || M_AXIS_TREADY;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q  <= IDLE;
      len_q    <= 32'd0;
      cnt_q    <= 32'd0;
      half_q   <= 1'b0;
      lo_q     <= 16'd0;
      tcnt_q   <= 16'd0;
      tdata_q  <= 32'd0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cr_start && (dsize != 32'd0)) begin
            len_q   <= dsize;
            cnt_q   <= 32'd0;
            half_q  <= 1'b0;
            tcnt_q  <= 16'd0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (tvalid_q && M_AXIS_TREADY) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
          end
          if (adc_valid) begin
            if (cr_test) tcnt_q <= tcnt_q + 16'd1;
            if (!half_q) begin
              lo_q   <= sample_d;
              half_q <= 1'b1;
            end else begin
              half_q <= 1'b0;
              if (can_load_d) begin
                tdata_q  <= {sample_d, lo_q};
                tvalid_q <= 1'b1;
                tlast_q  <= last_d;
                cnt_q    <= cnt_d;
                if (last_d) state_q <= DRAIN;
              end else begin
                ovf_q <= 1'b1;
              end
            end
          end
        end
        DRAIN: begin
          // Only the TLAST word can be pending here; samples are dropped silently.
          if (tvalid_q && M_AXIS_TREADY) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            done_q   <= 1'b1;
            if (cr_rt && (dsize != 32'd0)) begin
              len_q   <= dsize;
              cnt_q   <= 32'd0;
              half_q  <= 1'b0;
              state_q <= CAPTURE;
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign M_AXIS_TDATA  = tdata_q;
  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TLAST  = tlast_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign ovf           = ovf_q;

endmodule

// File: tb/tb_adc16dv160_capture_ctrl.sv
// tb/tb_adc16dv160_capture_ctrl.sv - directed bench for adc16dv160_capture_ctrl
module tb_adc16dv160_capture_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        cr_start, cr_test, cr_rt;
  logic [31:0] dsize;
  logic [15:0] adc_data;
  logic        adc_valid;
  logic [31:0] M_AXIS_TDATA;
  logic        M_AXIS_TVALID, M_AXIS_TREADY, M_AXIS_TLAST;
  logic        busy, done, ovf;

  int passed = 0;
  int total  = 0;

  always #5 ACLK = ~ACLK;

  adc16dv160_capture_ctrl dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .cr_start      (cr_start),
    .cr_test       (cr_test),
    .cr_rt         (cr_rt),
    .dsize         (dsize),
    .adc_data      (adc_data),
    .adc_valid     (adc_valid),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .busy          (busy),
    .done          (done),
    .ovf           (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic smp(input logic [15:0] d);
    adc_data  = d;
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
  endtask

  task automatic start(input logic [31:0] n);
    dsize    = n;
    cr_start = 1'b1;
    tick();
    cr_start = 1'b0;
  endtask

  initial begin
    ARESETN = 1'b0; cr_start = 1'b0; cr_test = 1'b0; cr_rt = 1'b0;
    dsize = 32'd0; adc_data = 16'd0; adc_valid = 1'b0; M_AXIS_TREADY = 1'b0;
    tick(); tick();
    chk("rst_tvalid", {31'd0, M_AXIS_TVALID}, 32'd0);
    chk("rst_tlast",  {31'd0, M_AXIS_TLAST}, 32'd0);
    chk("rst_tdata",  M_AXIS_TDATA, 32'd0);
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    chk("rst_done",   {31'd0, done}, 32'd0);
    chk("rst_ovf",    {31'd0, ovf}, 32'd0);
    ARESETN = 1'b1;
    tick();

    // test-counter packet, two words
    cr_test = 1'b1; M_AXIS_TREADY = 1'b1;
    start(32'd2);
    chk("a_busy", {31'd0, busy}, 32'd1);
    smp(16'h0); smp(16'h0);
    chk("a_w0_valid", {31'd0, M_AXIS_TVALID}, 32'd1);
    chk("a_w0_data",  M_AXIS_TDATA, 32'h0001_0000);
    chk("a_w0_last",  {31'd0, M_AXIS_TLAST}, 32'd0);
    smp(16'h0);
    chk("a_w0_taken", {31'd0, M_AXIS_TVALID}, 32'd0);
    smp(16'h0);
    chk("a_w1_data",  M_AXIS_TDATA, 32'h0003_0002);
    chk("a_w1_last",  {31'd0, M_AXIS_TLAST}, 32'd1);
    tick();
    chk("a_done",     {31'd0, done}, 32'd1);
    chk("a_busy_end", {31'd0, busy}, 32'd0);
    tick();
    chk("a_done_pulse", {31'd0, done}, 32'd0);

    // ADC data path, single word
    cr_test = 1'b0;
    start(32'd1);
    smp(16'h1234);
    chk("b_no_valid", {31'd0, M_AXIS_TVALID}, 32'd0);
    smp(16'h5678);
    chk("b_valid", {31'd0, M_AXIS_TVALID}, 32'd1);
    chk("b_data",  M_AXIS_TDATA, 32'h5678_1234);
    chk("b_last",  {31'd0, M_AXIS_TLAST}, 32'd1);
    tick();
    chk("b_done",  {31'd0, done}, 32'd1);
    tick();

    // backpressure overflow
    cr_test = 1'b1; M_AXIS_TREADY = 1'b0;
    start(32'd3);
    smp(16'h0); smp(16'h0);
    chk("c_w0_data", M_AXIS_TDATA, 32'h0001_0000);
    for (int i = 0; i < 4; i++) smp(16'h0);
    chk("c_held_data",  M_AXIS_TDATA, 32'h0001_0000);
    chk("c_held_valid", {31'd0, M_AXIS_TVALID}, 32'd1);
    chk("c_held_last",  {31'd0, M_AXIS_TLAST}, 32'd0);
    chk("c_ovf",        {31'd0, ovf}, 32'd1);
    M_AXIS_TREADY = 1'b1;
    tick();
    chk("c_w0_taken", {31'd0, M_AXIS_TVALID}, 32'd0);
    smp(16'h0); smp(16'h0);
    chk("c_w1_data", M_AXIS_TDATA, 32'h0007_0006);
    chk("c_w1_last", {31'd0, M_AXIS_TLAST}, 32'd0);
    smp(16'h0); smp(16'h0);
    chk("c_w2_data", M_AXIS_TDATA, 32'h0009_0008);
    chk("c_w2_last", {31'd0, M_AXIS_TLAST}, 32'd1);
    tick();
    chk("c_done",       {31'd0, done}, 32'd1);
    chk("c_ovf_sticky", {31'd0, ovf}, 32'd1);
    tick();

    // real-time mode, continuous samples
    cr_rt = 1'b1;
    start(32'd2);
    chk("d_ovf_clr", {31'd0, ovf}, 32'd0);
    adc_valid = 1'b1;
    tick(); tick();
    chk("d_p0w0", M_AXIS_TDATA, 32'h0001_0000);
    tick(); tick();
    chk("d_p0w1", M_AXIS_TDATA, 32'h0003_0002);
    chk("d_p0last", {31'd0, M_AXIS_TLAST}, 32'd1);
    tick();
    chk("d_p0done", {31'd0, done}, 32'd1);
    chk("d_p0busy", {31'd0, busy}, 32'd1);
    tick(); tick();
    chk("d_p1w0", M_AXIS_TDATA, 32'h0005_0004);
    tick(); tick();
    chk("d_p1w1", M_AXIS_TDATA, 32'h0007_0006);
    chk("d_p1last", {31'd0, M_AXIS_TLAST}, 32'd1);
    tick();
    chk("d_p1done", {31'd0, done}, 32'd1);
    tick(); tick();
    chk("d_p2w0", M_AXIS_TDATA, 32'h0009_0008);
    cr_rt = 1'b0;
    tick(); tick();
    chk("d_p2w1", M_AXIS_TDATA, 32'h000B_000A);
    chk("d_p2last", {31'd0, M_AXIS_TLAST}, 32'd1);
    tick();
    chk("d_p2done", {31'd0, done}, 32'd1);
    chk("d_idle",   {31'd0, busy}, 32'd0);
    tick();
    chk("d_stay_idle", {31'd0, busy}, 32'd0);
    adc_valid = 1'b0;
    tick();

    // ignored starts
    start(32'd0);
    chk("e_zero_busy",  {31'd0, busy}, 32'd0);
    chk("e_zero_valid", {31'd0, M_AXIS_TVALID}, 32'd0);
    tick();
    chk("e_zero_done",  {31'd0, done}, 32'd0);
    start(32'd2);
    smp(16'h0); smp(16'h0);
    chk("e_w0_data", M_AXIS_TDATA, 32'h0001_0000);
    start(32'd5);
    smp(16'h0); smp(16'h0);
    chk("e_w1_data", M_AXIS_TDATA, 32'h0003_0002);
    chk("e_w1_last", {31'd0, M_AXIS_TLAST}, 32'd1);
    tick();
    chk("e_done", {31'd0, done}, 32'd1);
    tick();

    // asynchronous reset mid-packet
    M_AXIS_TREADY = 1'b0;
    start(32'd2);
    smp(16'h0); smp(16'h0);
    chk("f_pre_valid", {31'd0, M_AXIS_TVALID}, 32'd1);
    #1 ARESETN = 1'b0;
    #1;
    chk("f_rst_valid", {31'd0, M_AXIS_TVALID}, 32'd0);
    chk("f_rst_data",  M_AXIS_TDATA, 32'd0);
    chk("f_rst_busy",  {31'd0, busy}, 32'd0);
    chk("f_rst_ovf",   {31'd0, ovf}, 32'd0);
    ARESETN = 1'b1;
    M_AXIS_TREADY = 1'b1;
    tick();
    smp(16'h0); smp(16'h0);
    chk("f_idle_valid", {31'd0, M_AXIS_TVALID}, 32'd0);
    chk("f_idle_busy",  {31'd0, busy}, 32'd0);
    chk("f_idle_done",  {31'd0, done}, 32'd0);
    start(32'd1);
    smp(16'h0); smp(16'h0);
    chk("f_new_data", M_AXIS_TDATA, 32'h0001_0000);
    chk("f_new_last", {31'd0, M_AXIS_TLAST}, 32'd1);
    tick();
    chk("f_new_done", {31'd0, done}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
